// File: rtl/uart_receiver.sv
// UART receive stage: 16x oversampled start/data/parity/stop recovery with
// a valid/ack host handshake and parity, framing and overrun status.
module uart_receiver #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_enable,
  input  logic       word_size,
  input  logic [1:0] parity_mode,
  input  logic       rx_in,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned MID    = OVERSAMPLE / 2;

  localparam logic [TICK_W-1:0] TICK_PRE  = TICK_W'(MID - 1);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(MID);
  localparam logic [TICK_W-1:0] TICK_POST = TICK_W'(MID + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [2:0]          bit_q, bit_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                s_in;
  logic [2:0]          samp_q;
  logic [7:0]          sh_q;
  logic                ws_q;
  logic [1:0]          pm_q;
  logic                par_err_q;
  logic                par_bit_q;
  logic                stop_q;
  logic                commit_q;
  logic                brk_hold_q;

  logic                start_c;
  logic                shift_c;
  logic                par_cap_c;
  logic                stop_cap_c;
  logic                maj_c;
  logic [2:0]          last_bit_c;
  logic                par_exp_c;
  logic                break_c;

  assign s_in       = sync_q[SYNC_STAGES-1];
  assign maj_c      = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  assign last_bit_c = ws_q ? 3'd7 : 3'd6;
  // bit7 of the shifter stays 0 in 7-bit mode, so the full XOR is correct
  assign par_exp_c  = (^sh_q) ^ (pm_q == 2'b10);
  // all-zero word, zero parity bit and low stop bit: line is in break
  assign break_c    = !s_in && (sh_q == 8'h00) && !par_bit_q;

  // rx_in metastability synchronizer, preset to the idle level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= rx_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // FSM state and bit-timing counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= 3'd0;
      rx_busy <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      rx_busy <= (state_d != IDLE);
    end
  end

  // next-state decode; everything advances only on sample ticks
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    start_c    = 1'b0;
    shift_c    = 1'b0;
    par_cap_c  = 1'b0;
    stop_cap_c = 1'b0;
    if (clk_enable) begin
      case (state_q)
        IDLE: begin
          if (!s_in && !brk_hold_q) begin
            state_d = START;
            tick_d  = '0;
            start_c = 1'b1;
          end
        end
        START: begin
          tick_d = tick_q + TICK_W'(1);
          if (tick_q == TICK_MID && s_in) begin
            state_d = IDLE;
            tick_d  = '0;
          end else if (tick_q == TICK_LAST) begin
            state_d = DATA;
            tick_d  = '0;
            bit_d   = 3'd0;
          end
        end
        DATA: begin
          tick_d = tick_q + TICK_W'(1);
          if (tick_q == TICK_LAST) begin
            shift_c = 1'b1;
            tick_d  = '0;
            if (bit_q == last_bit_c) begin
              bit_d   = 3'd0;
              state_d = (pm_q != 2'b00) ? PARITY : STOP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
        PARITY: begin
          tick_d = tick_q + TICK_W'(1);
          if (tick_q == TICK_LAST) begin
            par_cap_c = 1'b1;
            tick_d    = '0;
            state_d   = STOP;
          end
        end
        STOP: begin
          tick_d = tick_q + TICK_W'(1);
          if (tick_q == TICK_MID) begin
            stop_cap_c = 1'b1;
            tick_d     = '0;
            state_d    = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          tick_d  = '0;
        end
      endcase
    end
  end

  // mid-bit samples, data shifter, frame config and parity/stop capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_q    <= 3'b000;
      sh_q      <= 8'h00;
      ws_q      <= 1'b0;
      pm_q      <= 2'b00;
      par_err_q <= 1'b0;
      par_bit_q <= 1'b0;
      stop_q    <= 1'b1;
      commit_q  <= 1'b0;
    end else begin
      commit_q <= stop_cap_c;
      if (clk_enable) begin
        if (tick_q == TICK_PRE)  samp_q[0] <= s_in;
        if (tick_q == TICK_MID)  samp_q[1] <= s_in;
        if (tick_q == TICK_POST) samp_q[2] <= s_in;
      end
      if (start_c) begin
        sh_q      <= 8'h00;
        ws_q      <= word_size;
        pm_q      <= parity_mode;
        par_err_q <= 1'b0;
        par_bit_q <= 1'b0;
      end
      if (shift_c) sh_q[bit_q] <= maj_c;
      if (par_cap_c) begin
        par_bit_q <= maj_c;
        par_err_q <= (maj_c != par_exp_c);
      end
      if (stop_cap_c) stop_q <= s_in;
    end
  end

  // after a break word, hold off start detection until the line idles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brk_hold_q <= 1'b0;
    end else if (stop_cap_c && break_c) begin
      brk_hold_q <= 1'b1;
    end else if (state_q == IDLE && s_in) begin
      brk_hold_q <= 1'b0;
    end
  end

  // host handshake, runs every clk; a commit takes priority over an ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else if (commit_q) begin
      rx_data       <= sh_q;
      rx_valid      <= 1'b1;
      rx_parity_err <= par_err_q;
      rx_frame_err  <= !stop_q;
      rx_overrun    <= rx_valid && !rx_ack;
    end else if (rx_ack && rx_valid) begin
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver: line frames driven tick by tick,
// expected words and flags written out by hand per scenario.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_enable;
  logic       word_size;
  logic [1:0] parity_mode;
  logic       rx_in;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;

  int checks   = 0;
  int failures = 0;

  logic ack_req    = 1'b0;
  logic auto_ack   = 1'b0;
  logic auto_pulse = 1'b0;
  logic prev_valid = 1'b0;
  int   busy_cnt   = 0;
  int   valid_rises = 0;
  logic [9:0] wq[$];

  assign rx_ack = auto_ack ? auto_pulse : ack_req;

  uart_receiver #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_enable   (clk_enable),
    .word_size    (word_size),
    .parity_mode  (parity_mode),
    .rx_in        (rx_in),
    .rx_ack       (rx_ack),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  // sample tick every 4th clk
  initial begin
    int cnt;
    cnt = 0;
    clk_enable = 1'b0;
    forever begin
      @(negedge clk);
      clk_enable = (cnt == 3);
      cnt = (cnt + 1) % 4;
    end
  end

  // output monitor: busy/valid activity and optional auto-ack word log
  initial begin
    forever begin
      @(negedge clk);
      if (rx_busy === 1'b1) busy_cnt++;
      if (rx_valid === 1'b1 && prev_valid !== 1'b1) valid_rises++;
      prev_valid = rx_valid;
      if (auto_ack && rx_valid === 1'b1 && !auto_pulse) begin
        wq.push_back({rx_parity_err, rx_frame_err, rx_data});
        auto_pulse = 1'b1;
      end else begin
        auto_pulse = 1'b0;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_tick();
    @(posedge clk);
    while (clk_enable !== 1'b1) @(posedge clk);
  endtask

  task automatic send_bit(input logic v, input int n);
    #1 rx_in = v;
    repeat (n) wait_tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic has_par,
                            input logic par_bit, input logic stop_bit, input int stop_ticks);
    send_bit(1'b0, 16);
    for (int i = 0; i < nbits; i++) send_bit(d[i[2:0]], 16);
    if (has_par) send_bit(par_bit, 16);
    send_bit(stop_bit, stop_ticks);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 200 && rx_valid !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic host_ack();
    @(negedge clk) ack_req = 1'b1;
    @(negedge clk) ack_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_in = 1'b1; word_size = 1'b1; parity_mode = 2'b00;
    repeat (3) @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    checks++; if (rx_parity_err !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", rx_parity_err); end
    checks++; if (rx_frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", rx_frame_err); end
    checks++; if (rx_overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", rx_overrun); end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
    @(negedge clk) reset = 1'b0;
    send_bit(1'b1, 20);
  endtask

  task automatic test_8n1();
    int r0;
    word_size = 1'b1; parity_mode = 2'b00;
    r0 = valid_rises;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 16);
    wait_valid();
    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL 8n1_valid got=%b exp=1", rx_valid); end
    checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL 8n1_data got=%h exp=a5", rx_data); end
    checks++; if (rx_parity_err !== 1'b0) begin failures++; $display("FAIL 8n1_perr got=%b exp=0", rx_parity_err); end
    checks++; if (rx_frame_err !== 1'b0) begin failures++; $display("FAIL 8n1_ferr got=%b exp=0", rx_frame_err); end
    checks++; if (rx_overrun !== 1'b0) begin failures++; $display("FAIL 8n1_overrun got=%b exp=0", rx_overrun); end
    checks++; if (valid_rises - r0 != 1) begin failures++; $display("FAIL 8n1_rises got=%0d exp=1", valid_rises - r0); end
    host_ack();
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL 8n1_ack_clear got=%b exp=0", rx_valid); end
    @(negedge clk) ack_req = 1'b1;
    @(negedge clk) ack_req = 1'b0;
    checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL 8n1_idle_ack_data got=%h exp=a5", rx_data); end
  endtask

  task automatic test_parity();
    word_size = 1'b0; parity_mode = 2'b01;
    send_bit(1'b1, 4);
    // 0x55 in 7 bits has four ones: even parity bit is 0
    send_frame(8'h55, 7, 1'b1, 1'b0, 1'b1, 16);
    wait_valid();
    checks++; if (rx_data !== 8'h55) begin failures++; $display("FAIL par_good_data got=%h exp=55", rx_data); end
    checks++; if (rx_parity_err !== 1'b0) begin failures++; $display("FAIL par_good_perr got=%b exp=0", rx_parity_err); end
    checks++; if (rx_frame_err !== 1'b0) begin failures++; $display("FAIL par_good_ferr got=%b exp=0", rx_frame_err); end
    host_ack();
    send_frame(8'h55, 7, 1'b1, 1'b1, 1'b1, 16);
    wait_valid();
    checks++; if (rx_data !== 8'h55) begin failures++; $display("FAIL par_bad_data got=%h exp=55", rx_data); end
    checks++; if (rx_parity_err !== 1'b1) begin failures++; $display("FAIL par_bad_perr got=%b exp=1", rx_parity_err); end
    host_ack();
    checks++; if (rx_parity_err !== 1'b0) begin failures++; $display("FAIL par_ack_clear got=%b exp=0", rx_parity_err); end
    word_size = 1'b1; parity_mode = 2'b00;
  endtask

  task automatic test_back_to_back();
    word_size = 1'b1; parity_mode = 2'b00;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 16);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 16);
    checks++; if (rx_data !== 8'h22) begin failures++; $display("FAIL b2b_data got=%h exp=22", rx_data); end
    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", rx_valid); end
    checks++; if (rx_overrun !== 1'b1) begin failures++; $display("FAIL b2b_overrun got=%b exp=1", rx_overrun); end
    // stop mid is sampled on the 10th tick of the stop bit; commit is one clk later
    send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1, 10);
    #1;
    checks++; if (rx_data !== 8'h22) begin failures++; $display("FAIL b2b_precommit_data got=%h exp=22", rx_data); end
    ack_req = 1'b1;
    @(posedge clk);
    #1 ack_req = 1'b0;
    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL b2b_same_valid got=%b exp=1", rx_valid); end
    checks++; if (rx_data !== 8'h33) begin failures++; $display("FAIL b2b_same_data got=%h exp=33", rx_data); end
    checks++; if (rx_overrun !== 1'b0) begin failures++; $display("FAIL b2b_same_overrun got=%b exp=0", rx_overrun); end
    send_bit(1'b1, 6);
  endtask

  task automatic test_reset_mid();
    send_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 16);
    send_bit(1'b1, 8);
    #1;
    checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL rmid_busy_before got=%b exp=1", rx_busy); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rmid_data got=%h exp=00", rx_data); end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", rx_busy); end
    checks++; if (rx_overrun !== 1'b0) begin failures++; $display("FAIL rmid_overrun got=%b exp=0", rx_overrun); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send_bit(1'b1, 20);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 16);
    wait_valid();
    checks++; if (rx_data !== 8'h81) begin failures++; $display("FAIL rmid_next_data got=%h exp=81", rx_data); end
    checks++; if (rx_frame_err !== 1'b0 || rx_parity_err !== 1'b0) begin failures++; $display("FAIL rmid_next_err got=%b%b exp=00", rx_frame_err, rx_parity_err); end
    checks++; if (rx_overrun !== 1'b0) begin failures++; $display("FAIL rmid_next_overrun got=%b exp=0", rx_overrun); end
    host_ack();
  endtask

  task automatic test_frame_break();
    int n0;
    logic [9:0] w;
    word_size = 1'b1; parity_mode = 2'b00;
    auto_ack = 1'b1;
    n0 = wq.size();
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 16);
    send_bit(1'b0, 320);
    checks++; if (wq.size() - n0 != 2) begin failures++; $display("FAIL brk_count got=%0d exp=2", wq.size() - n0); end
    if (wq.size() >= n0 + 2) begin
      w = wq[n0];
      checks++; if (w !== {1'b0, 1'b1, 8'h3C}) begin failures++; $display("FAIL brk_word0 got=%h exp=%h", w, {1'b0, 1'b1, 8'h3C}); end
      w = wq[n0 + 1];
      checks++; if (w !== {1'b0, 1'b1, 8'h00}) begin failures++; $display("FAIL brk_word1 got=%h exp=%h", w, {1'b0, 1'b1, 8'h00}); end
    end
    send_bit(1'b1, 48);
    checks++; if (wq.size() - n0 != 2) begin failures++; $display("FAIL brk_after_high got=%0d exp=2", wq.size() - n0); end
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 16);
    send_bit(1'b1, 4);
    checks++; if (wq.size() - n0 != 3) begin failures++; $display("FAIL brk_rearm_count got=%0d exp=3", wq.size() - n0); end
    if (wq.size() >= n0 + 3) begin
      w = wq[n0 + 2];
      checks++; if (w !== {1'b0, 1'b0, 8'h5A}) begin failures++; $display("FAIL brk_rearm_word got=%h exp=%h", w, {1'b0, 1'b0, 8'h5A}); end
    end
    auto_ack = 1'b0;
  endtask

  task automatic test_glitch();
    int b0, n0;
    auto_ack = 1'b1;
    b0 = busy_cnt;
    n0 = wq.size();
    send_bit(1'b0, 5);
    send_bit(1'b1, 30);
    checks++; if (busy_cnt - b0 <= 0) begin failures++; $display("FAIL glitch_busy_pulse got=%0d exp>0", busy_cnt - b0); end
    checks++; if (busy_cnt - b0 >= 64) begin failures++; $display("FAIL glitch_busy_len got=%0d exp<64", busy_cnt - b0); end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_end got=%b exp=0", rx_busy); end
    checks++; if (wq.size() != n0) begin failures++; $display("FAIL glitch_words got=%0d exp=0", wq.size() - n0); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL glitch_valid got=%b exp=0", rx_valid); end
    auto_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    test_frame_break();
    test_glitch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
